// File: rtl/spi_byte_tx_if.sv
// Control-side handshake between the SpiControl stage and spi_byte_tx.
// The transmit byte is named tx_byte because "byte" is a SystemVerilog keyword.
interface spi_byte_tx_if;
    logic       send;
    logic [7:0] tx_byte;
    logic       ready;
    logic       busy;
    logic       done;
    logic       overrun;
    logic [7:0] rx_byte;

    modport master (
        output send, tx_byte,
        input  ready, busy, done, overrun, rx_byte
    );

    modport slave (
        input  send, tx_byte,
        output ready, busy, done, overrun, rx_byte
    );
endinterface

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte transmitter/receiver with a one-entry holding buffer
// that lets back-to-back bytes share a single ss_n frame.
module spi_byte_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clock,
    input  logic         reset,
    spi_byte_tx_if.slave ctrl,
    output logic         sclk,
    output logic         mosi,
    output logic         ss_n,
    input  logic         miso
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  half_q, half_d;
    logic        chain_q, chain_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_full_q, hold_full_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        ss_n_q, ss_n_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  rx_byte_q, rx_byte_d;

    logic        div_end_s;
    logic        accept_s;

    assign div_end_s = (div_q == DIV_LAST);
    assign accept_s  = ctrl.send && ready_q;

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        half_d      = half_q;
        chain_d     = chain_q;
        shift_d     = shift_q;
        rx_sh_d     = rx_sh_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        ss_n_d      = ss_n_q;
        rx_byte_d   = rx_byte_q;
        done_d      = 1'b0;
        overrun_d   = ctrl.send && !ready_q;

        // Outside IDLE an accepted byte waits in the holding buffer.
        if (accept_s && (state_q != IDLE)) begin
            hold_data_d = ctrl.tx_byte;
            hold_full_d = 1'b1;
        end else begin
            hold_data_d = hold_data_q;
        end

        case (state_q)
            IDLE: begin
                div_d   = 16'd0;
                half_d  = 4'd0;
                chain_d = 1'b0;
                if (accept_s) begin
                    shift_d = ctrl.tx_byte;
                    mosi_d  = ctrl.tx_byte[7];
                    ss_n_d  = 1'b0;
                    state_d = SETUP;
                end else if (hold_full_q) begin
                    shift_d     = hold_data_q;
                    mosi_d      = hold_data_q[7];
                    hold_full_d = 1'b0;
                    ss_n_d      = 1'b0;
                    state_d     = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (div_end_s) begin
                    div_d   = 16'd0;
                    half_d  = 4'd0;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], miso};
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            SHIFT: begin
                if (!div_end_s) begin
                    div_d = div_q + 16'd1;
                end else if (half_q == 4'd15) begin
                    // End of the final low half-period: either start the chained byte or trail off.
                    div_d = 16'd0;
                    if (chain_q) begin
                        half_d  = 4'd0;
                        chain_d = 1'b0;
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], miso};
                    end else begin
                        state_d = TRAIL;
                    end
                end else begin
                    div_d  = 16'd0;
                    half_d = half_q + 4'd1;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        rx_sh_d = {rx_sh_q[6:0], miso};
                    end else if (half_q == 4'd14) begin
                        done_d    = 1'b1;
                        rx_byte_d = rx_sh_q;
                        if (hold_full_q) begin
                            shift_d     = hold_data_q;
                            mosi_d      = hold_data_q[7];
                            hold_full_d = 1'b0;
                            chain_d     = 1'b1;
                        end else begin
                            chain_d = 1'b0;
                        end
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        mosi_d  = shift_q[6];
                    end
                end
            end
            TRAIL: begin
                if (div_end_s) begin
                    div_d   = 16'd0;
                    ss_n_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            GAP: begin
                if (div_end_s) begin
                    div_d   = 16'd0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
                ss_n_d  = 1'b1;
                div_d   = 16'd0;
            end
        endcase

        ready_d = !hold_full_d;
        busy_d  = !((state_d == IDLE) && !hold_full_d);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= 16'd0;
            half_q      <= 4'd0;
            chain_q     <= 1'b0;
            shift_q     <= 8'd0;
            rx_sh_q     <= 8'd0;
            hold_data_q <= 8'd0;
            hold_full_q <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ss_n_q      <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            rx_byte_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            half_q      <= half_d;
            chain_q     <= chain_d;
            shift_q     <= shift_d;
            rx_sh_q     <= rx_sh_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ss_n_q      <= ss_n_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            rx_byte_q   <= rx_byte_d;
        end
    end

    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign ss_n         = ss_n_q;
    assign ctrl.ready   = ready_q;
    assign ctrl.busy    = busy_q;
    assign ctrl.done    = done_q;
    assign ctrl.overrun = overrun_q;
    assign ctrl.rx_byte = rx_byte_q;
endmodule

// File: tb/tb_spi_byte_tx.sv
// Scoreboarded bench for spi_byte_tx: a CLK_DIV=2 instance for most scenarios
// and a CLK_DIV=1 instance for the fastest divider setting.
module tb_spi_byte_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_byte_tx_if if2 ();
    spi_byte_tx_if if1 ();
    logic sclk2, mosi2, ss_n2, miso2;
    logic sclk1, mosi1, ss_n1, miso1;
    logic miso_one = 1'b0;

    assign miso2 = miso_one ? 1'b1 : mosi2;
    assign miso1 = mosi1;

    spi_byte_tx #(.CLK_DIV(2)) dut2 (
        .clock(clk), .reset(rst_n), .ctrl(if2),
        .sclk(sclk2), .mosi(mosi2), .ss_n(ss_n2), .miso(miso2)
    );

    spi_byte_tx #(.CLK_DIV(1)) dut1 (
        .clock(clk), .reset(rst_n), .ctrl(if1),
        .sclk(sclk1), .mosi(mosi1), .ss_n(ss_n1), .miso(miso1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard entries are {mosi byte seen at sclk rises, rx_byte at done}.
    logic [15:0] exp2[$];
    logic [15:0] exp1[$];
    logic [15:0] obs2[$];
    logic [15:0] obs1[$];
    int          rd2 = 0;
    int          rd1 = 0;
    int          ovr2 = 0;
    logic [7:0]  tx_sh2 = 8'd0;
    logic [7:0]  tx_sh1 = 8'd0;
    logic        sclk2_prev = 1'b0;
    logic        sclk1_prev = 1'b0;

    // Output monitor: rebuild the mosi byte at each sclk rise and log each done pulse.
    always @(negedge clk) begin
        sclk2_prev <= sclk2;
        sclk1_prev <= sclk1;
        if (sclk2 && !sclk2_prev) tx_sh2 <= {tx_sh2[6:0], mosi2};
        if (sclk1 && !sclk1_prev) tx_sh1 <= {tx_sh1[6:0], mosi1};
        if (if2.done) obs2.push_back({tx_sh2, if2.rx_byte});
        if (if1.done) obs1.push_back({tx_sh1, if1.rx_byte});
        if (if2.overrun) ovr2 <= ovr2 + 1;
    end

    task automatic test_reset();
        logic [14:0] got;
        if2.send = 1'b0; if2.tx_byte = 8'h00;
        if1.send = 1'b0; if1.tx_byte = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {if2.ready, if2.busy, if2.done, if2.overrun, ss_n2, sclk2, mosi2, if2.rx_byte};
        n_cmp++;
        if (got !== 15'b100_0100_0000_0000) begin
            n_bad++;
            $display("FAIL reset_held: outputs got %b expected %b", got, 15'b100_0100_0000_0000);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        got = {if2.ready, if2.busy, if2.done, if2.overrun, ss_n2, sclk2, mosi2, if2.rx_byte};
        n_cmp++;
        if (got !== 15'b100_0100_0000_0000) begin
            n_bad++;
            $display("FAIL reset_released: outputs got %b expected %b", got, 15'b100_0100_0000_0000);
        end
    endtask

    task automatic test_single();
        int k, first_rise, done_k, ssn_k, ndone;
        logic [15:0] e;
        if2.tx_byte = 8'hA5; if2.send = 1'b1;
        exp2.push_back({8'hA5, 8'hA5});
        @(negedge clk);
        if2.send = 1'b0;
        k = 0; first_rise = -1; done_k = -1; ssn_k = -1; ndone = 0;
        while (k < 200 && (k < 2 || if2.busy)) begin
            if (sclk2 && first_rise < 0) first_rise = k;
            if (if2.done) begin ndone++; if (done_k < 0) done_k = k; end
            if (ss_n2 && ssn_k < 0) ssn_k = k;
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (if2.busy !== 1'b0) begin n_bad++; $display("FAIL single_timeout: busy got %b expected 0", if2.busy); end
        n_cmp++;
        if (first_rise !== 2) begin n_bad++; $display("FAIL single_first_rise: cycle got %0d expected 2", first_rise); end
        n_cmp++;
        if (done_k !== 32 || ndone !== 1) begin
            n_bad++; $display("FAIL single_done: cycle %0d count %0d expected cycle 32 count 1", done_k, ndone);
        end
        n_cmp++;
        if (ssn_k !== 36) begin n_bad++; $display("FAIL single_ss_n_high: cycle got %0d expected 36", ssn_k); end
        while (exp2.size() > 0) begin
            e = exp2.pop_front();
            n_cmp++;
            if (rd2 >= obs2.size()) begin
                n_bad++; $display("FAIL single_sb: no byte, expected tx/rx %h", e);
            end else begin
                if (obs2[rd2] !== e) begin n_bad++; $display("FAIL single_sb: tx/rx got %h expected %h", obs2[rd2], e); end
                rd2++;
            end
        end
    endtask

    task automatic test_chain();
        int k, ssn_k, nrise, d1, d2, ovr0;
        logic prev;
        logic [15:0] e;
        ovr0 = ovr2;
        if2.tx_byte = 8'h3C; if2.send = 1'b1;
        exp2.push_back({8'h3C, 8'h3C});
        @(negedge clk);
        if2.send = 1'b0;
        k = 0; ssn_k = -1; nrise = 0; d1 = -1; d2 = -1; prev = 1'b0;
        while (k < 300 && (k < 5 || if2.busy)) begin
            if (sclk2 && !prev) nrise++;
            prev = sclk2;
            if (if2.done) begin if (d1 < 0) d1 = k; else d2 = k; end
            if (ss_n2 && ssn_k < 0) ssn_k = k;
            if (k == 3) begin
                if2.tx_byte = 8'hF0; if2.send = 1'b1;
                exp2.push_back({8'hF0, 8'hF0});
            end else begin
                if2.send = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (if2.busy !== 1'b0) begin n_bad++; $display("FAIL chain_timeout: busy got %b expected 0", if2.busy); end
        n_cmp++;
        if (ssn_k !== 68) begin n_bad++; $display("FAIL chain_frame: ss_n high at cycle %0d expected 68", ssn_k); end
        n_cmp++;
        if (nrise !== 16) begin n_bad++; $display("FAIL chain_rises: got %0d expected 16", nrise); end
        n_cmp++;
        if (d1 !== 32 || d2 !== 64) begin n_bad++; $display("FAIL chain_done: cycles %0d,%0d expected 32,64", d1, d2); end
        n_cmp++;
        if (ovr2 - ovr0 !== 0) begin n_bad++; $display("FAIL chain_overrun: got %0d expected 0", ovr2 - ovr0); end
        while (exp2.size() > 0) begin
            e = exp2.pop_front();
            n_cmp++;
            if (rd2 >= obs2.size()) begin
                n_bad++; $display("FAIL chain_sb: no byte, expected tx/rx %h", e);
            end else begin
                if (obs2[rd2] !== e) begin n_bad++; $display("FAIL chain_sb: tx/rx got %h expected %h", obs2[rd2], e); end
                rd2++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int k, ovr0;
        logic [15:0] e;
        ovr0 = ovr2;
        if2.tx_byte = 8'h11; if2.send = 1'b1; exp2.push_back({8'h11, 8'h11});
        @(negedge clk);
        if2.tx_byte = 8'h22; exp2.push_back({8'h22, 8'h22});
        @(negedge clk);
        if2.tx_byte = 8'h33;
        @(negedge clk);
        if2.send = 1'b0;
        n_cmp++;
        if (if2.overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_overrun_pulse: got %b expected 1", if2.overrun); end
        for (k = 0; k < 300 && if2.busy; k++) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (if2.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: busy got %b expected 0", if2.busy); end
        n_cmp++;
        if (ovr2 - ovr0 !== 1) begin n_bad++; $display("FAIL b2b_overrun_count: got %0d expected 1", ovr2 - ovr0); end
        while (exp2.size() > 0) begin
            e = exp2.pop_front();
            n_cmp++;
            if (rd2 >= obs2.size()) begin
                n_bad++; $display("FAIL b2b_sb: no byte, expected tx/rx %h", e);
            end else begin
                if (obs2[rd2] !== e) begin n_bad++; $display("FAIL b2b_sb: tx/rx got %h expected %h", obs2[rd2], e); end
                rd2++;
            end
        end
        n_cmp++;
        if (obs2.size() != rd2) begin
            n_bad++; $display("FAIL b2b_extra: got %0d extra bytes expected 0", obs2.size() - rd2);
            rd2 = obs2.size();
        end
    endtask

    task automatic test_miso_high();
        int k, mosi_high;
        logic [15:0] e;
        miso_one = 1'b1;
        if2.tx_byte = 8'h00; if2.send = 1'b1;
        exp2.push_back({8'h00, 8'hFF});
        @(negedge clk);
        if2.send = 1'b0;
        mosi_high = 0;
        for (k = 0; k < 300 && if2.busy; k++) begin
            if (mosi2 !== 1'b0) mosi_high++;
            @(negedge clk);
        end
        miso_one = 1'b0;
        n_cmp++;
        if (mosi_high !== 0 || if2.busy !== 1'b0) begin
            n_bad++; $display("FAIL miso_high_mosi: high cycles %0d busy %b expected 0 and 0", mosi_high, if2.busy);
        end
        while (exp2.size() > 0) begin
            e = exp2.pop_front();
            n_cmp++;
            if (rd2 >= obs2.size()) begin
                n_bad++; $display("FAIL miso_high_sb: no byte, expected tx/rx %h", e);
            end else begin
                if (obs2[rd2] !== e) begin n_bad++; $display("FAIL miso_high_sb: tx/rx got %h expected %h", obs2[rd2], e); end
                rd2++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, nrise, nobs;
        logic prev;
        logic [15:0] e;
        if2.tx_byte = 8'hC3; if2.send = 1'b1;
        @(negedge clk);
        if2.send = 1'b0;
        nrise = 0; prev = 1'b0;
        for (k = 0; k < 200 && nrise < 4; k++) begin
            if (sclk2 && !prev) nrise++;
            prev = sclk2;
            if (nrise < 4) @(negedge clk);
        end
        nobs = obs2.size();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ss_n2, sclk2, if2.busy, if2.ready} !== 4'b1001 || nrise !== 4) begin
            n_bad++;
            $display("FAIL reset_mid_abort: ss_n/sclk/busy/ready %b rises %0d expected 1001 and 4",
                     {ss_n2, sclk2, if2.busy, if2.ready}, nrise);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        if2.tx_byte = 8'h81; if2.send = 1'b1;
        exp2.push_back({8'h81, 8'h81});
        n_cmp++;
        if (obs2.size() !== nobs) begin n_bad++; $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", obs2.size() - nobs); end
        @(negedge clk);
        if2.send = 1'b0;
        n_cmp++;
        if ({ss_n2, if2.busy} !== 2'b01) begin n_bad++; $display("FAIL reset_mid_accept: ss_n/busy got %b expected 01", {ss_n2, if2.busy}); end
        for (k = 0; k < 300 && if2.busy; k++) @(negedge clk);
        @(negedge clk);
        while (exp2.size() > 0) begin
            e = exp2.pop_front();
            n_cmp++;
            if (rd2 >= obs2.size()) begin
                n_bad++; $display("FAIL reset_mid_sb: no byte, expected tx/rx %h", e);
            end else begin
                if (obs2[rd2] !== e) begin n_bad++; $display("FAIL reset_mid_sb: tx/rx got %h expected %h", obs2[rd2], e); end
                rd2++;
            end
        end
    endtask

    task automatic test_clkdiv1();
        int k, r1, r2, done_k, ssn_k;
        logic prev;
        logic [15:0] e;
        if1.tx_byte = 8'h55; if1.send = 1'b1;
        exp1.push_back({8'h55, 8'h55});
        @(negedge clk);
        if1.send = 1'b0;
        k = 0; r1 = -1; r2 = -1; done_k = -1; ssn_k = -1; prev = 1'b0;
        while (k < 100 && (k < 2 || if1.busy)) begin
            if (sclk1 && !prev) begin if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k; end
            prev = sclk1;
            if (if1.done && done_k < 0) done_k = k;
            if (ss_n1 && ssn_k < 0) ssn_k = k;
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (r1 !== 1 || r2 !== 3) begin n_bad++; $display("FAIL div1_sclk: rises at %0d,%0d expected 1,3", r1, r2); end
        n_cmp++;
        if (done_k !== 16) begin n_bad++; $display("FAIL div1_done: cycle got %0d expected 16", done_k); end
        n_cmp++;
        if (ssn_k !== 18 || if1.busy !== 1'b0) begin
            n_bad++; $display("FAIL div1_frame: ss_n high at %0d busy %b expected 18 and 0", ssn_k, if1.busy);
        end
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            n_cmp++;
            if (rd1 >= obs1.size()) begin
                n_bad++; $display("FAIL div1_sb: no byte, expected tx/rx %h", e);
            end else begin
                if (obs1[rd1] !== e) begin n_bad++; $display("FAIL div1_sb: tx/rx got %h expected %h", obs1[rd1], e); end
                rd1++;
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single();
        test_chain();
        test_back_to_back();
        test_miso_high();
        test_reset_mid();
        test_clkdiv1();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spi_byte_tx.md
SPI_BYTE_TX -- requirements
Module: spi_byte_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system clocks per SCLK half-period (legal range 1..65535).
REQ-002 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port send  in  1  one-cycle request from the SpiControl stage to transmit byte.
REQ-005 SHALL have port byte  in  8  byte to transmit, MSB first, sampled when send is accepted.
REQ-006 SHALL have port ready  out  1  high when a send in this cycle will be accepted.
REQ-007 SHALL have port busy  out  1  high from send acceptance until return to IDLE.
REQ-008 SHALL have port done  out  1  one-cycle pulse per completed byte.
REQ-009 SHALL have port overrun  out  1  one-cycle pulse when send arrives while ready=0.
REQ-010 SHALL have port rx_byte  out  8  byte captured from miso, updated with done.
REQ-011 SHALL have ports sclk, mosi, ss_n  out  1 each, and miso  in  1; SPI mode 0 (CPOL=0, CPHA=0).

Function
REQ-012 SHALL implement states IDLE, SETUP, SHIFT, TRAIL, GAP with a one-entry holding buffer (hold_data, hold_full).
REQ-013 SHALL drive ready = !hold_full, registered; ready=1 in IDLE.
REQ-014 IDLE + send: SHALL load byte into the shift register and enter SETUP next cycle with ss_n=0, mosi=byte[7], sclk=0; hold buffer stays empty.
REQ-015 Non-IDLE + send + ready=1: SHALL store byte in hold_data and set hold_full next cycle.
REQ-016 send with ready=0: SHALL drop byte, pulse overrun next cycle, and leave all other state unchanged.
REQ-017 SETUP SHALL last CLK_DIV cycles, then enter SHIFT.
REQ-018 SHIFT SHALL toggle sclk every CLK_DIV cycles via a 16-bit divider counter, 16 half-periods per byte (16*CLK_DIV cycles).
REQ-019 On each sclk rising edge, SHALL shift miso into the receive register; mosi SHALL be unchanged.
REQ-020 On falling edges 1..7, SHALL advance mosi to the next lower bit.
REQ-021 On the 8th falling edge, SHALL pulse done and update rx_byte in the same cycle.
REQ-022 8th falling edge with hold_full=1: SHALL load hold_data into the shift register, drive mosi=hold_data[7], clear hold_full, and stay in SHIFT with ss_n=0 and no extra gap.
REQ-023 8th falling edge with hold_full=0: SHALL enter TRAIL (CLK_DIV cycles, ss_n=0, sclk=0).
REQ-024 After TRAIL: SHALL enter GAP (CLK_DIV cycles, ss_n=1), then IDLE.
REQ-025 A send during TRAIL or GAP SHALL go to the hold buffer; it SHALL be launched as a new frame from IDLE on the cycle after GAP ends.
REQ-026 Simultaneous send and hold-buffer drain (8th falling edge) SHALL treat ready as its registered value; a send with ready=0 SHALL be dropped and flagged per REQ-016.
REQ-027 busy SHALL be 0 only in IDLE with hold_full=0.
REQ-028 mosi SHALL hold its last value in TRAIL, GAP and IDLE, and SHALL be 0 after reset.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, ss_n=1, sclk=0, mosi=0, ready=1, busy=0, done=0, overrun=0, rx_byte=0, hold_full=0, and clear the counters.
REQ-030 Reset asserted mid-byte SHALL abort the frame with no done pulse; after release the block SHALL accept send on the first clock edge.

Verification
REQ-031 CLK_DIV=2, send byte=0xA5, miso looped to mosi -> ss_n low 2 cycles before the first sclk rise; mosi 1,0,1,0,0,1,0,1 at the rises; done once; rx_byte=0xA5; ss_n high after 2+32+2 cycles.
REQ-032 CLK_DIV=2, send 0x3C then 0xF0 four cycles later -> single ss_n-low frame with 16 sclk rises, two done pulses 32 cycles apart, no overrun.
REQ-033 Send three bytes back-to-back while busy -> second buffered, third dropped with one overrun pulse; only two bytes transmitted.
REQ-034 miso tied to 1, send 0x00 -> mosi low throughout; rx_byte=0xFF.
REQ-035 Assert reset after the 4th sclk rise -> ss_n=1 and sclk=0 immediately, no done; after release, a fresh send 0x81 transmits correctly.
REQ-036 CLK_DIV=1, send 0x55 -> sclk period 2 cycles, byte completes in 16 SHIFT cycles, rx_byte correct.
